// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data SRAM arbiter: FSM states,
// SRAM address-space prefixes and address composition helpers.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    F_LO = 3'd1,
    F_HI = 3'd2,
    D_RD = 3'd3,
    D_WR = 3'd4,
    DONE = 3'd5
  } arb_state_t;

  localparam logic       FETCH_SPACE = 1'b0;
  localparam logic [1:0] DATA_SPACE  = 2'b10;

  // Instruction words occupy two consecutive 16-bit SRAM locations; hi selects the upper half.
  function automatic logic [17:0] fetch_addr(input logic [15:0] addr, input logic hi);
    return {FETCH_SPACE, addr, hi};
  endfunction

  function automatic logic [17:0] data_addr(input logic [15:0] addr);
    return {DATA_SPACE, addr};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Beat-length timer: loads WAIT_STATES at the start of an SRAM beat and counts
// down; last_cycle flags the final cycle of the beat.
module mem_wait_timer #(
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_cycle
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WAIT_STATES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last_cycle = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 16-bit SRAM between the cpu fetch port (two-beat 32-bit fetch)
// and its data port, with wait-stated beats and a one-cycle completion pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        d_rd,
  input  logic        d_wr,
  output logic [15:0] d_rdata,
  output logic        d_busy,
  output logic        d_ready,
  input  logic [15:0] f_addr,
  input  logic        f_req,
  output logic [31:0] f_instr,
  output logic        f_valid,
  output logic [17:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  output logic        m_cs,
  output logic        m_oe,
  output logic        m_we
);

  arb_state_t  state;
  logic [15:0] instr_lo;
  logic        last_cycle;
  logic        beat_start;

  // A new beat starts on acceptance in IDLE and when the low fetch beat hands over to the high one.
  assign beat_start = ((state == IDLE) && (d_rd || d_wr || f_req)) ||
                      ((state == F_LO) && last_cycle);

  assign d_busy = (d_rd | d_wr) & ~d_ready;

  mem_wait_timer #(
    .WAIT_STATES (WAIT_STATES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (beat_start),
    .last_cycle (last_cycle)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_cs     <= 1'b0;
      m_oe     <= 1'b0;
      m_we     <= 1'b0;
      d_ready  <= 1'b0;
      d_rdata  <= '0;
      f_valid  <= 1'b0;
      f_instr  <= '0;
      instr_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Data takes priority over fetch; a simultaneous read and write is treated as a write.
          if (d_wr) begin
            m_addr  <= data_addr(d_addr);
            m_wdata <= d_wdata;
            m_cs    <= 1'b1;
            m_we    <= 1'b1;
            state   <= D_WR;
          end else if (d_rd) begin
            m_addr <= data_addr(d_addr);
            m_cs   <= 1'b1;
            m_oe   <= 1'b1;
            state  <= D_RD;
          end else if (f_req) begin
            m_addr <= fetch_addr(f_addr, 1'b0);
            m_cs   <= 1'b1;
            m_oe   <= 1'b1;
            state  <= F_LO;
          end
        end
        F_LO: begin
          if (last_cycle) begin
            instr_lo <= m_rdata;
            m_addr   <= fetch_addr(m_addr[16:1], 1'b1);
            state    <= F_HI;
          end
        end
        F_HI: begin
          if (last_cycle) begin
            f_instr <= {m_rdata, instr_lo};
            f_valid <= 1'b1;
            m_cs    <= 1'b0;
            m_oe    <= 1'b0;
            state   <= DONE;
          end
        end
        D_RD: begin
          if (last_cycle) begin
            d_rdata <= m_rdata;
            d_ready <= 1'b1;
            m_cs    <= 1'b0;
            m_oe    <= 1'b0;
            state   <= DONE;
          end
        end
        D_WR: begin
          if (last_cycle) begin
            d_ready <= 1'b1;
            m_cs    <= 1'b0;
            m_we    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          // Requests are deliberately not sampled here so a still-held level cannot re-trigger.
          d_ready <= 1'b0;
          f_valid <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
